reg_file_fwd: RTL and testbench
===============================

REG_FILE_FWD -- requirements
Module: reg_file_fwd

Interface
REQ-001 SHALL have parameter DW, default 32: register and data width.
REQ-002 SHALL have parameter AW, default 5: register address width, giving 2**AW entries.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port rs_addr, input, AW: read port A address.
REQ-006 SHALL have port rs_use, input, 1: read port A is consumed by the instruction in decode.
REQ-007 SHALL have port rt_addr, input, AW: read port B address.
REQ-008 SHALL have port rt_use, input, 1: read port B is consumed by the instruction in decode.
REQ-009 SHALL have port ex_wen, input, 1: EX/MEM stage will write a register.
REQ-010 SHALL have port ex_addr, input, AW: EX/MEM destination.
REQ-011 SHALL have port ex_data, input, DW: EX/MEM result.
REQ-012 SHALL have port ex_load, input, 1: EX/MEM result is a pending load, so ex_data is not yet valid.
REQ-013 SHALL have port wb_wen, input, 1: MEM/WB commit enable.
REQ-014 SHALL have port wb_addr, input, AW: MEM/WB commit destination.
REQ-015 SHALL have port wb_data, input, DW: MEM/WB commit data.
REQ-016 SHALL have port rs_data, output, DW: read port A result.
REQ-017 SHALL have port rt_data, output, DW: read port B result.
REQ-018 SHALL have port stall, output, 1: load-use hazard; hold IF/ID and insert a bubble.
REQ-019 SHALL have port commit_cnt, output, 16: saturating count of committed writes.
REQ-020 SHALL have port stall_cnt, output, 16: saturating count of stall cycles.

Function
REQ-021 SHALL hold 2**AW registers of DW bits; entry 0 SHALL always read 0 and SHALL ignore writes.
REQ-022 SHALL commit wb_data into entry wb_addr on the rising clk edge when wb_wen=1 and wb_addr!=0.
REQ-023 SHALL make a commit visible in the array from the following cycle.
REQ-024 SHALL compute rs_data and rt_data combinationally, independently per port, with this priority:
  - (a) address 0 -> 0;
  - (b) ex_wen=1, ex_load=0, ex_addr==address -> ex_data;
  - (c) wb_wen=1, wb_addr==address -> wb_data (same-cycle write-through);
  - (d) otherwise the array entry.
REQ-025 SHALL select ex_data over wb_data when ex_addr==wb_addr==read address and both sources are enabled (youngest wins).
REQ-026 SHALL skip source (b) when ex_load=1 and ex_addr matches; it SHALL fall through to (c)/(d), and stall covers the hazard.
REQ-027 SHALL assert stall combinationally when ex_wen=1, ex_load=1, ex_addr!=0 and ((rs_use=1 and rs_addr==ex_addr) or (rt_use=1 and rt_addr==ex_addr)); otherwise stall=0.
REQ-028 SHALL increment commit_cnt by 1 per clock edge on which REQ-022 commits, saturating at 16'hFFFF.
REQ-029 SHALL not count writes to entry 0 in commit_cnt.
REQ-030 SHALL increment stall_cnt by 1 per clock edge on which stall=1, saturating at 16'hFFFF with no wrap.
REQ-031 SHALL update both counters on the same edge when a commit and a stall occur in the same cycle.
REQ-032 SHALL have zero latency on read and bypass paths and one cycle from wb_wen to the array.

Reset
REQ-033 SHALL, while rst=0, asynchronously clear all register entries, commit_cnt and stall_cnt to 0.
REQ-034 SHALL, during reset, drive rs_data/rt_data as 0 unless a combinational bypass source is active; stall still follows REQ-027.
REQ-035 SHALL discard any commit whose edge coincides with rst=0.
REQ-036 SHALL perform the first commit on the first rising edge with rst=1.

Verification
REQ-037 SHALL cover commit-then-read: wb_wen=1, wb_addr=5, wb_data=32'hDEADBEEF, one edge, then rs_addr=5 with no bypass active -> rs_data=32'hDEADBEEF and commit_cnt=1.
REQ-038 SHALL cover bypass priority: ex_wen=1, ex_addr=7, ex_data=32'h11 and wb_wen=1, wb_addr=7, wb_data=32'h22, rs_addr=rt_addr=7 -> both outputs 32'h11; with ex_wen=0 -> both 32'h22.
REQ-039 SHALL cover load-use: ex_wen=1, ex_load=1, ex_addr=3, rt_addr=3, rt_use=1 -> stall=1 and stall_cnt increments per edge; with rt_use=0 or ex_addr=0 -> stall=0.
REQ-040 SHALL cover register zero: wb_wen=1, wb_addr=0, wb_data=32'hFFFFFFFF, plus ex_wen=1, ex_addr=0 -> rs_addr=0 reads 0 and commit_cnt is unchanged.
REQ-041 SHALL cover saturation: 65536 stall cycles -> stall_cnt=16'hFFFF and remains there on further stalls.
REQ-042 SHALL cover reset mid-operation: after writing entry 9, pulse rst=0 between clock edges -> entry 9, commit_cnt and stall_cnt read 0 immediately.

Source files
------------

// File: rtl/reg_file_fwd.sv
// Register file with same-cycle forwarding from EX/MEM and MEM/WB, load-use
// stall detection, and saturating commit/stall event counters.
module reg_file_fwd #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs_addr,
    input  logic          rs_use,
    input  logic [AW-1:0] rt_addr,
    input  logic          rt_use,
    input  logic          ex_wen,
    input  logic [AW-1:0] ex_addr,
    input  logic [DW-1:0] ex_data,
    input  logic          ex_load,
    input  logic          wb_wen,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic          stall,
    output logic [15:0]   commit_cnt,
    output logic [15:0]   stall_cnt
);

    localparam int          NREG    = 2 ** AW;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [DW-1:0] regs_q [NREG];
    logic [15:0]   commit_cnt_q, commit_cnt_d;
    logic [15:0]   stall_cnt_q, stall_cnt_d;
    logic          commit;
    logic          ex_fwd_ok;

    // A write to entry 0 is architecturally a no-op and is not counted.
    assign commit = wb_wen && (wb_addr != '0);

    // EX/MEM can forward only once its result is real (not a pending load).
    assign ex_fwd_ok = ex_wen && !ex_load;

    // Load-use hazard: a consumed source matches a pending load destination.
    assign stall = ex_wen && ex_load && (ex_addr != '0) &&
                   ((rs_use && (rs_addr == ex_addr)) ||
                    (rt_use && (rt_addr == ex_addr)));

    // Read port A: zero register, then youngest producer, then array.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rs_data = regs_q[rs_addr];
        if (rs_addr == '0)
            rs_data = '0;
        else if (ex_fwd_ok && (ex_addr == rs_addr))
            rs_data = ex_data;
        else if (wb_wen && (wb_addr == rs_addr))
            rs_data = wb_data;
    end

    // Read port B: same priority as port A, evaluated independently.
    always_comb begin
        rt_data = regs_q[rt_addr];
        if (rt_addr == '0)
            rt_data = '0;
        else if (ex_fwd_ok && (ex_addr == rt_addr))
            rt_data = ex_data;
        else if (wb_wen && (wb_addr == rt_addr))
            rt_data = wb_data;
    end

    // Saturating next-state for both event counters.
    always_comb begin
        commit_cnt_d = commit_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (commit && (commit_cnt_q != CNT_MAX))
            commit_cnt_d = commit_cnt_q + 16'd1;
        if (stall && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // Register array: cleared by reset, written by MEM/WB commits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the array is flops, not a RAM macro, so it can and must clear on reset.
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else if (commit) begin
            // NOTE: state updates use <= so every flop samples pre-edge values.
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            commit_cnt_q <= commit_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign commit_cnt = commit_cnt_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_reg_file_fwd.sv
// Randomized and directed bench for reg_file_fwd against an array-based model.
module tb_reg_file_fwd;

    logic        clk;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr, ex_addr, wb_addr;
    logic        rs_use, rt_use, ex_wen, ex_load, wb_wen;
    logic [31:0] ex_data, wb_data;
    logic [31:0] rs_data, rt_data;
    logic        stall;
    logic [15:0] commit_cnt, stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: plain array plus integer counters.
    logic [31:0] m_regs [32];
    int          m_commit;
    int          m_stall;

    reg_file_fwd dut (
        .clk        (clk),
        .rst        (rst),
        .rs_addr    (rs_addr),
        .rs_use     (rs_use),
        .rt_addr    (rt_addr),
        .rt_use     (rt_use),
        .ex_wen     (ex_wen),
        .ex_addr    (ex_addr),
        .ex_data    (ex_data),
        .ex_load    (ex_load),
        .wb_wen     (wb_wen),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .stall      (stall),
        .commit_cnt (commit_cnt),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0)                               return 32'd0;
        if (ex_wen && !ex_load && ex_addr == a)      return ex_data;
        if (wb_wen && wb_addr == a)                  return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_stall();
        return ex_wen && ex_load && (ex_addr != 5'd0) &&
               ((rs_use && rs_addr == ex_addr) || (rt_use && rt_addr == ex_addr));
    endfunction

    // Model update on the same edges as the design.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
            m_commit <= 0;
            m_stall  <= 0;
        end else begin
            if (wb_wen && wb_addr != 5'd0) begin
                m_regs[wb_addr] <= wb_data;
                m_commit <= (m_commit < 65535) ? m_commit + 1 : 65535;
            end
            if (exp_stall())
                m_stall <= (m_stall < 65535) ? m_stall + 1 : 65535;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("rs_data",    rs_data,            exp_read(rs_addr));
        check("rt_data",    rt_data,            exp_read(rt_addr));
        check("stall",      32'(stall),         32'(exp_stall()));
        check("commit_cnt", 32'(commit_cnt),    32'(m_commit));
        check("stall_cnt",  32'(stall_cnt),     32'(m_stall));
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        rs_addr = '0; rt_addr = '0; ex_addr = '0; wb_addr = '0;
        rs_use = 1'b0; rt_use = 1'b0; ex_wen = 1'b0; ex_load = 1'b0; wb_wen = 1'b0;
        ex_data = '0; wb_data = '0;

        // Reset state.
        repeat (2) next_cycle();
        rs_addr = 5'd5;
        #1;
        check("rst_rs_data",    rs_data,          32'h0);
        check("rst_commit_cnt", 32'(commit_cnt),  32'h0);
        check("rst_stall_cnt",  32'(stall_cnt),   32'h0);
        rst = 1'b1;

        // Commit then read back from the array.
        next_cycle();
        wb_wen = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        next_cycle();
        wb_wen = 1'b0; rs_addr = 5'd5;
        #1;
        check("commit_read", rs_data,         32'hDEADBEEF);
        check("commit_cnt1", 32'(commit_cnt), 32'd1);

        // Bypass priority: EX/MEM beats MEM/WB, then MEM/WB write-through.
        ex_wen = 1'b1; ex_addr = 5'd7; ex_data = 32'h11;
        wb_wen = 1'b1; wb_addr = 5'd7; wb_data = 32'h22;
        rs_addr = 5'd7; rt_addr = 5'd7;
        #1;
        check("byp_ex_rs", rs_data, 32'h11);
        check("byp_ex_rt", rt_data, 32'h11);
        ex_wen = 1'b0;
        #1;
        check("byp_wb_rs", rs_data, 32'h22);
        check("byp_wb_rt", rt_data, 32'h22);
        next_cycle();
        wb_wen = 1'b0;

        // Load-use hazard; the pending load must not forward its data.
        ex_wen = 1'b1; ex_load = 1'b1; ex_addr = 5'd3; ex_data = 32'h33;
        rt_addr = 5'd3; rt_use = 1'b1; rs_addr = 5'd3; rs_use = 1'b0;
        #1;
        check("lu_stall",     32'(stall),     32'd1);
        check("lu_no_fwd",    rs_data,        32'h0);
        check("lu_cnt0",      32'(stall_cnt), 32'd0);
        repeat (3) next_cycle();
        check("lu_cnt3",      32'(stall_cnt), 32'd3);
        rt_use = 1'b0;
        #1;
        check("lu_unused",    32'(stall),     32'd0);
        rt_use = 1'b1; ex_addr = 5'd0; rt_addr = 5'd0;
        #1;
        check("lu_zero",      32'(stall),     32'd0);
        ex_wen = 1'b0; ex_load = 1'b0; rt_use = 1'b0;
        next_cycle();

        // Register zero ignores writes and forwarding.
        wb_wen = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        ex_wen = 1'b1; ex_addr = 5'd0; ex_data = 32'h55; rs_addr = 5'd0;
        #1;
        check("r0_read", rs_data, 32'h0);
        next_cycle();
        check("r0_cnt",  32'(commit_cnt), 32'd2);
        wb_wen = 1'b0; ex_wen = 1'b0;

        // Commit on an edge under reset is discarded; first edge after release commits.
        rst = 1'b0;
        wb_wen = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
        next_cycle();
        rst = 1'b1; wb_wen = 1'b0; rs_addr = 5'd6;
        #1;
        check("rstedge_rd",  rs_data,         32'h0);
        check("rstedge_cnt", 32'(commit_cnt), 32'd0);
        wb_wen = 1'b1;
        next_cycle();
        wb_wen = 1'b0;
        #1;
        check("first_commit_rd",  rs_data,         32'h66);
        check("first_commit_cnt", 32'(commit_cnt), 32'd1);

        // Reset mid-operation clears the array and counters immediately.
        next_cycle();
        wb_wen = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        next_cycle();
        wb_wen = 1'b0; rs_addr = 5'd9;
        #1;
        check("mid_pre_rd",  rs_data,         32'h99);
        check("mid_pre_cnt", 32'(commit_cnt), 32'd2);
        rst = 1'b0;
        #1;
        check("mid_rd",      rs_data,         32'h0);
        check("mid_commit",  32'(commit_cnt), 32'h0);
        check("mid_stall",   32'(stall_cnt),  32'h0);
        rst = 1'b1;

        // Stall counter saturation with concurrent random commits.
        next_cycle();
        ex_wen = 1'b1; ex_load = 1'b1; ex_addr = 5'd4; rs_use = 1'b1; rs_addr = 5'd4;
        repeat (65536) begin
            next_cycle();
            wb_wen  = 1'($urandom_range(0, 1));
            wb_addr = 5'($urandom_range(0, 31));
            wb_data = $urandom;
        end
        check("sat_stall",  32'(stall_cnt), 32'hFFFF);
        repeat (5) next_cycle();
        check("sat_hold",   32'(stall_cnt), 32'hFFFF);
        ex_wen = 1'b0; ex_load = 1'b0; rs_use = 1'b0; wb_wen = 1'b0;

        // Random traffic with narrow addresses so hazards and bypasses collide.
        repeat (3000) begin
            next_cycle();
            rs_addr = 5'($urandom_range(0, 7));
            rt_addr = 5'($urandom_range(0, 7));
            ex_addr = 5'($urandom_range(0, 7));
            wb_addr = 5'($urandom_range(0, 7));
            rs_use  = 1'($urandom_range(0, 1));
            rt_use  = 1'($urandom_range(0, 1));
            ex_wen  = 1'($urandom_range(0, 1));
            ex_load = ($urandom_range(0, 2) == 0);
            wb_wen  = 1'($urandom_range(0, 1));
            ex_data = $urandom;
            wb_data = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                #1;
                rst = 1'b1;
            end
        end

        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
